// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices, the
// zero register number and the shadow-pipeline entry layout.
package pipeline_hazard_ctrl_pkg;

    localparam int STAGE_EX  = 1;
    localparam int STAGE_MEM = 2;
    localparam int STAGE_WB  = 3;

    localparam logic [4:0] REG_ZR = 5'd31;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       is_load;
    } shadow_entry_t;

    // True when this in-flight instruction produces the register the operand reads.
    function automatic logic entry_writes(input shadow_entry_t e,
                                          input logic [4:0]    r,
                                          input logic          used);
        return e.valid && e.regwrite && used && (e.rd == r) && (e.rd != REG_ZR);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_operand_match.sv
// Compares one ID source operand against every shadow entry and reports the
// forwarding source it will need in EX plus whether a load is still too young.
module hazard_operand_match
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int NSTAGE         = STAGE_WB,
    parameter int LOAD_FWD_STAGE = STAGE_WB,
    parameter int FW             = $clog2(NSTAGE + 1)
) (
    input  shadow_entry_t [NSTAGE:1] entries_i,
    input  logic [4:0]               reg_i,
    input  logic                     used_i,
    output logic [FW-1:0]            sel_o,
    output logic                     load_hit_o
);

    always_comb begin
        sel_o      = '0;
        load_hit_o = 1'b0;
        // Scan from the oldest forwardable entry down so the youngest producer wins;
        // an entry at stage k sits one stage further on once the consumer reaches EX.
        for (int k = NSTAGE - 1; k >= STAGE_EX; k--) begin
            if (entry_writes(entries_i[k], reg_i, used_i)) begin
                sel_o = FW'(k - STAGE_EX + STAGE_MEM);
            end
        end
        for (int k = STAGE_EX; k <= NSTAGE; k++) begin
            if (entry_writes(entries_i[k], reg_i, used_i) && entries_i[k].is_load
                && (k + 1 < LOAD_FWD_STAGE)) begin
                load_hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: tracks in-flight destinations in a shadow pipeline and
// derives forwarding selects, load-use stalls, memory freezes and flushes.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int  NSTAGE         = STAGE_WB,
    parameter int  LOAD_FWD_STAGE = STAGE_WB,
    parameter int  FLUSH_STAGES   = 0,
    parameter int  CNT_W          = 32,
    localparam int FW             = $clog2(NSTAGE + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic [4:0]       id_rd,
    input  logic             id_rn_used,
    input  logic             id_rm_used,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    input  logic             mem_wait,
    output logic             stall,
    output logic             bubble,
    output logic             freeze,
    output logic             flush_ifid,
    output logic [FW-1:0]    ex_fwd_a,
    output logic [FW-1:0]    ex_fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    shadow_entry_t [NSTAGE:1] shadow_q, shadow_d;
    logic                     flush_pend_q, flush_pend_d;
    logic [FW-1:0]            fwd_a_q, fwd_a_d;
    logic [FW-1:0]            fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;

    logic [FW-1:0]            sel_a, sel_b;
    logic                     hit_a, hit_b;
    logic                     flush_eff, load_use, stall_int;

    hazard_operand_match #(
        .NSTAGE         (NSTAGE),
        .LOAD_FWD_STAGE (LOAD_FWD_STAGE),
        .FW             (FW)
    ) u_match_rn (
        .entries_i  (shadow_q),
        .reg_i      (id_rn),
        .used_i     (id_rn_used),
        .sel_o      (sel_a),
        .load_hit_o (hit_a)
    );

    hazard_operand_match #(
        .NSTAGE         (NSTAGE),
        .LOAD_FWD_STAGE (LOAD_FWD_STAGE),
        .FW             (FW)
    ) u_match_rm (
        .entries_i  (shadow_q),
        .reg_i      (id_rm),
        .used_i     (id_rm_used),
        .sel_o      (sel_b),
        .load_hit_o (hit_b)
    );

    // A memory wait freezes everything and postpones any flush; a flush wins over
    // a load-use stall because the stalled ID instruction is being discarded anyway.
    always_comb begin
        flush_eff  = (flush | flush_pend_q) & ~mem_wait;
        load_use   = id_valid & (hit_a | hit_b) & ~mem_wait;
        stall_int  = load_use & ~flush_eff;
        stall      = stall_int & ~reset;
        bubble     = (load_use | flush_eff) & ~reset;
        freeze     = mem_wait & ~reset;
        flush_ifid = flush_eff & ~reset;
    end

    always_comb begin
        shadow_d     = shadow_q;
        flush_pend_d = flush_pend_q;
        fwd_a_d      = fwd_a_q;
        fwd_b_d      = fwd_b_q;
        stall_cnt_d  = stall_cnt_q;
        if (mem_wait) begin
            flush_pend_d = flush_pend_q | flush;
        end else begin
            flush_pend_d = 1'b0;
            fwd_a_d      = sel_a;
            fwd_b_d      = sel_b;
            if (stall_int && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            // The youngest FLUSH_STAGES entries are squashed as they advance.
            for (int k = NSTAGE; k > STAGE_EX; k--) begin
                shadow_d[k] = shadow_q[k-1];
                if (flush_eff && ((k - 1) <= FLUSH_STAGES)) begin
                    shadow_d[k].valid = 1'b0;
                end
            end
            shadow_d[STAGE_EX] = '{valid:    id_valid & ~stall_int & ~flush_eff,
                                   rd:       id_rd,
                                   regwrite: id_regwrite,
                                   is_load:  id_memread};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_q     <= '0;
            flush_pend_q <= 1'b0;
            fwd_a_q      <= '0;
            fwd_b_q      <= '0;
            stall_cnt_q  <= '0;
        end else begin
            shadow_q     <= shadow_d;
            flush_pend_q <= flush_pend_d;
            fwd_a_q      <= fwd_a_d;
            fwd_b_q      <= fwd_b_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign ex_fwd_a  = fwd_a_q;
    assign ex_fwd_b  = fwd_b_q;
    assign stall_cnt = stall_cnt_q;

    // A frozen pipe never stalls, and every stall is accompanied by a bubble.
    assert property (@(posedge clock) disable iff (reset) freeze |-> (!stall && !bubble));
    assert property (@(posedge clock) disable iff (reset) stall |-> bubble);

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 3: tracked stages after decode (1=EX, 2=MEM, 3=WB), range 2..6.
REQ-002 SHALL have parameter LOAD_FWD_STAGE, default 3: lowest stage from which load data is forwardable, range 2..NSTAGE.
REQ-003 SHALL have parameter FLUSH_STAGES, default 0: tracked stages (from stage 1 upward) invalidated by flush, in addition to ID.
REQ-004 SHALL have parameter CNT_W, default 32: stall-counter width.
REQ-005 SHALL have ports, where FW = clog2(NSTAGE+1):
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rn, id_rm, id_rd  in  5 each  source and destination register numbers.
- id_rn_used, id_rm_used  in  1 each  operand actually read.
- id_regwrite, id_memread  in  1 each  writes rd; is a load.
- flush  in  1  branch redirect, one-cycle pulse.
- mem_wait  in  1  data memory not ready.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  zero ID/EX control fields.
- freeze  out  1  hold every pipeline register.
- flush_ifid  out  1  clear IF/ID.
- ex_fwd_a, ex_fwd_b  out  FW each  EX operand source: 0 = register file, k = stage k result.
- stall_cnt  out  CNT_W  load-use stall cycles, saturating.

Function
REQ-006 SHALL keep an NSTAGE-entry shadow pipeline of {valid, rd, regwrite, is_load}; on each cycle without freeze, entry k moves to k+1, entry NSTAGE is discarded, and entry 1 loads ID fields (valid = id_valid & ~stall & ~flush_eff).
REQ-007 SHALL treat entry k as a match for operand X when valid, regwrite, X_used, rd == X, and rd != 31 (XZR never creates a dependence).
REQ-008 SHALL register ex_fwd_a/ex_fwd_b at the same edge that moves ID into EX, with value k+1 for the smallest matching k in 1..NSTAGE-1, and 0 when there is no match.
REQ-009 SHALL assert stall and bubble combinationally when a matching entry k has is_load and k+1 < LOAD_FWD_STAGE; on a stall, forwarding selects SHALL be recomputed on the following cycle.
REQ-010 SHALL assert freeze combinationally while mem_wait; stall and bubble SHALL be 0; shadow entries, fwd selects and stall_cnt SHALL hold.
REQ-011 SHALL define flush_eff = (flush | flush_pend) & ~mem_wait; flush_ifid = flush_eff.
REQ-012 SHALL make flush_eff invalidate the ID instruction (as in REQ-006) and entries 1..FLUSH_STAGES before the shift.
REQ-013 SHALL set flush_pend when flush arrives during mem_wait, and clear it in the first cycle without mem_wait.
REQ-014 SHALL let flush_eff override a load-use stall in the same cycle: stall = 0, bubble = 1.
REQ-015 SHALL increment stall_cnt by 1 in each cycle with stall = 1, saturating at all-ones.
REQ-016 SHALL produce an outcome for an operand with id_valid = 0 that never causes stall.

Reset
REQ-017 SHALL, with reset high at a clock edge, clear all shadow valids, flush_pend, ex_fwd_a, ex_fwd_b and stall_cnt to 0; stall, bubble, freeze and flush_ifid SHALL then read 0.
REQ-018 SHALL give reset priority over mem_wait, flush and stall, and SHALL discard a pending flush.

Structure
REQ-019 SHALL place stage index constants, REG_ZR = 31 and the shadow-entry typedef in the shared pipeline package.
REQ-020 SHALL instantiate sub-module hazard_operand_match twice (Rn, Rm); each returns the match select and the load-use hit.

Verification
REQ-021 ADD X1 then SUB X2,X1,X3 back-to-back -> ex_fwd_a = 2 in the SUB's EX cycle, no stall.
REQ-022 LDUR X5 then ADD X6,X5,X5 -> one cycle of stall = bubble = 1, then ex_fwd_a = ex_fwd_b = 3, stall_cnt = 1.
REQ-023 Producer writes X31, consumer reads X31 -> ex_fwd = 0, no stall.
REQ-024 mem_wait held 4 cycles with flush pulsed in cycle 2 -> freeze = 1 for 4 cycles, flush_ifid = 1 in cycle 5 only.
REQ-025 Load-use stall coincident with flush -> stall = 0, bubble = 1, flush_ifid = 1, stall_cnt unchanged.
REQ-026 NSTAGE = 5, LOAD_FWD_STAGE = 4, load followed by dependent -> 2 stall cycles; reset asserted during the second -> all outputs 0 next cycle.
